nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit add/subtract unit that feeds operands one nibble per cycle through a 4-bit carry-lookahead slice.
- Keeps the ripple carry between nibbles in a register.
- Sits upstream of the 4-bit CLA: it sequences operand nibbles and carry-in into the slice and collects sum nibbles and carry-out.
- Exposes a valid/ready handshake on both sides for the datapath/ALU wrapper.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 8.
- NIBS, WIDTH/4, derived nibble count; sets the number of RUN cycles.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  operands and op present.
- in_ready  output  1  block can accept a new operation.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in for add; ignored when sub=1.
- sub  input  1  0: A+B+Cin; 1: A-B.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- Sum  output  WIDTH  result.
- Cout  output  1  carry-out of MSB. For sub, 1 means no borrow.
- Ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- Zero  output  1  Sum == 0.

Behaviour:
- Reset (async, any state): state=IDLE, nibble counter=0, carry reg=0, in_ready=1, out_valid=0, Sum=0, Cout=0, Ovf=0, Zero=0.
  - An operation in flight is abandoned with no output.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready:
    - latch A into opA.
    - latch B into opB, or ~B when sub=1.
    - carry reg = sub ? 1 : Cin.
    - cnt=0, then go to RUN.
  - RUN: in_ready=0. Each cycle:
    - slice inputs are opA[4*cnt+:4], opB[4*cnt+:4] and carry reg.
    - slice sum is written to Sum[4*cnt+:4]; carry reg is updated with the slice carry-out.
    - when cnt==NIBS-1, also capture the slice's carry into bit 3 for Ovf, then go to DONE.
    - otherwise cnt++.
  - DONE: out_valid=1, in_ready=0.
    - Cout = carry reg; Ovf = c3 ^ carry reg; Zero = (Sum==0).
    - On out_ready, go to IDLE next edge (out_valid drops, in_ready rises). No same-cycle re-accept.
- Latency: accept at edge k → out_valid=1 after edge k+NIBS (k+4 for WIDTH=16). Throughput is one op per NIBS+2 cycles.
- Backpressure: while out_valid && !out_ready, Sum/Cout/Ovf/Zero are held stable and in_valid is ignored.
- Sum, Cout, Ovf and Zero are defined only while out_valid=1. After leaving DONE they hold their last value until the next RUN overwrites them.
- Width rules: all arithmetic is modulo 2^WIDTH, with no sign extension. Sub is computed as A + ~B + 1.
- in_valid deasserted or operands changing during RUN/DONE: no effect, since operands are latched.

Decomposition:
- Shared package/header:
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - NIB_W=4.
- Natural sub-module: cla_nibble. Combinational 4-bit carry-lookahead with inputs x[3:0], y[3:0], ci and outputs s[3:0], co, c3 (carry into bit 3).
  - It is instantiated once and time-multiplexed over the nibbles.
- Top level contains the FSM, counter, operand and carry registers, and result flags.

Test Plan:
- Add with Cin=0: A=0x1234, B=0x4321 → Sum=0x5555, Cout=0, Ovf=0, Zero=0; out_valid exactly 4 edges after the accept edge.
- Carry through all nibbles: A=0xFFFF, B=0x0001, Cin=0 → Sum=0x0000, Cout=1, Zero=1, Ovf=0. Also A=0x000F, B=0, Cin=1 → Sum=0x0010, Cout=0.
- Signed overflow: A=0x7FFF, B=0x0001, add → Sum=0x8000, Ovf=1, Cout=0.
- Subtract with borrow: A=0x0005, B=0x0007, sub=1, Cin=1 (ignored) → Sum=0xFFFE, Cout=0, Ovf=0. Then A=0x8000, B=0x0001, sub → Sum=0x7FFF, Ovf=1, Cout=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands → outputs unchanged, in_ready=0, no accept. Raise out_ready → IDLE next cycle, then the new op is accepted.
- Reset mid-operation: assert rst 2 cycles into RUN → out_valid=0 and in_ready=1 immediately, all outputs 0. After release, A=0x0101, B=0x1010 → Sum=0x1111.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial add/subtract unit.
package nibble_serial_adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serial_adder_cla_nibble.sv
// Combinational 4-bit carry-lookahead slice; also exports the carry into bit 3
// so the top can form signed overflow on the most significant nibble.
module cla_nibble
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIB_W-1:0] x,
  input  logic [NIB_W-1:0] y,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             co,
  output logic             c3
);

  logic [NIB_W-1:0] g;
  logic [NIB_W-1:0] p;
  logic [NIB_W-1:0] c;

  assign g = x & y;
  assign p = x ^ y;

  // Every carry is flattened to generate/propagate terms of ci; no ripple path.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c;
  assign c3 = c[3];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract that time-multiplexes one 4-bit CLA slice over the
// operand nibbles, with valid/ready handshakes on input and result.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero
);

  localparam int NIBS  = WIDTH / NIB_W;
  localparam int CNT_W = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBS - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   opa_q;
  logic [WIDTH-1:0]   opb_q;
  logic               carry_q;
  logic [WIDTH-1:0]   sum_q;
  logic [WIDTH-1:0]   sum_d;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               cout_q;
  logic               ovf_q;
  logic               zero_q;

  logic [NIB_W-1:0]   slice_s;
  logic               slice_co;
  logic               slice_c3;

  cla_nibble u_slice (
    .x  (opa_q[NIB_W*cnt_q +: NIB_W]),
    .y  (opb_q[NIB_W*cnt_q +: NIB_W]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co),
    .c3 (slice_c3)
  );

  // NOTE: give every always_comb output a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    sum_d = sum_q;
    sum_d[NIB_W*cnt_q +: NIB_W] = slice_s;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            opa_q      <= A;
            opb_q      <= sub ? ~B : B;
            carry_q    <= sub ? 1'b1 : Cin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= slice_co;
          if (cnt_q == LAST_NIB) begin
            // Flags are formed from the final slice so they appear with out_valid.
            cout_q      <= slice_co;
            ovf_q       <= slice_c3 ^ slice_co;
            zero_q      <= (sum_d == '0);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder at WIDTH=16.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Sum;
  logic        Cout;
  logic        Ovf;
  logic        Zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .Ovf       (Ovf),
    .Zero      (Zero)
  );

  // Present one operation, wait for the accept edge, then count edges until
  // out_valid (bounded at 20 edges).
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic s, output int lat);
    @(negedge clk);
    A = a; B = b; Cin = cin; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Result {Sum, Cout, Ovf, Zero} and latency check for one complete operation.
  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic s, input logic [15:0] e_sum,
                        input logic e_cout, input logic e_ovf, input logic e_zero);
    int lat;
    issue(a, b, cin, s, lat);
    n_checks++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL %s latency: got %0d edges, expected 4", name, lat);
    end
    n_checks++;
    if ({Sum, Cout, Ovf, Zero} !== {e_sum, e_cout, e_ovf, e_zero}) begin
      n_fail++;
      $display("FAIL %s result: got Sum=%h C=%b V=%b Z=%b, expected Sum=%h C=%b V=%b Z=%b",
               name, Sum, Cout, Ovf, Zero, e_sum, e_cout, e_ovf, e_zero);
    end
    consume();
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL %s release: got out_valid=%b in_ready=%b, expected 0 1",
               name, out_valid, in_ready);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_checks++;
    if ({out_valid, in_ready, Sum, Cout, Ovf, Zero} !== {1'b0, 1'b1, 16'h0, 3'b000}) begin
      n_fail++;
      $display("FAIL %s: got out_valid=%b in_ready=%b Sum=%h C=%b V=%b Z=%b, expected 0 1 0000 0 0 0",
               name, out_valid, in_ready, Sum, Cout, Ovf, Zero);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    int lat;
    issue(16'h1234, 16'h4321, 1'b0, 1'b0, lat);
    n_checks++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL add_latency: got %0d edges, expected 4", lat);
    end
    n_checks++;
    if ({Sum, Cout, Ovf, Zero, in_ready} !== {16'h5555, 4'b0000}) begin
      n_fail++;
      $display("FAIL add_basic: got Sum=%h C=%b V=%b Z=%b rdy=%b, expected 5555 0 0 0 0",
               Sum, Cout, Ovf, Zero, in_ready);
    end
    consume();
    run_op("carry_all", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("cin_one",   16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0);
    run_op("ovf_add",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_sub();
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_op("sub_equal",  16'hA5A5, 16'hA5A5, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    int lat;
    issue(16'h1234, 16'h1111, 1'b0, 1'b0, lat);
    @(negedge clk);
    A = 16'h0002; B = 16'h0003; Cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, in_ready, Sum, Cout, Ovf, Zero} !== {2'b10, 16'h2345, 3'b000}) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: got out_valid=%b in_ready=%b Sum=%h C=%b V=%b Z=%b, expected 1 0 2345 0 0 0",
                 i, out_valid, in_ready, Sum, Cout, Ovf, Zero);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL backpressure_release: got out_valid=%b in_ready=%b, expected 0 1",
               out_valid, in_ready);
    end
    issue(16'h0002, 16'h0003, 1'b0, 1'b0, lat);
    n_checks++;
    if (lat !== 4 || Sum !== 16'h0005) begin
      n_fail++;
      $display("FAIL backpressure_next: got latency=%0d Sum=%h, expected 4 0005", lat, Sum);
    end
    consume();
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid_run");
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_reset_outputs("reset_no_output");
    run_op("after_reset", 16'h0101, 16'h1010, 1'b0, 1'b0, 16'h1111, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
